// File: rtl/ysyx_25040109_iter_mdu_if.sv
// Request/response bundle between the execute stage (master) and the iterative MDU (slave).
interface ysyx_25040109_iter_mdu_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_funct3;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_funct3, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  modport slave (
    input  in_valid, in_funct3, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );
endinterface

// File: rtl/ysyx_25040109_iter_mdu.sv
// Iterative RV32M unit: radix-2 shift-add multiplier and restoring divider on
// operand magnitudes, sign fixed up on the way into DONE.
module ysyx_25040109_iter_mdu #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input logic                     clk,
  input logic                     rst,
  input logic                     flush,
  ysyx_25040109_iter_mdu_if.slave io
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [1:0]         f3_q, f3_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               sa_q, sa_d, sb_q, sb_d;
  logic [XLEN-1:0]    opb_q, opb_d;   // multiplicand / divisor magnitude
  logic [2*XLEN-1:0]  acc_q, acc_d;   // mul: {high, multiplier}; div: low half dividend->quotient
  logic [XLEN:0]      rem_q, rem_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [XLEN-1:0]    res_q, res_d;

  // request decode
  logic            sa_in, sb_in, ovf_in;
  logic [XLEN-1:0] amag_in, bmag_in;

  always_comb begin
    sa_in   = io.in_a[XLEN-1] & (io.in_funct3 == 3'b001 || io.in_funct3 == 3'b010 ||
                                 io.in_funct3 == 3'b100 || io.in_funct3 == 3'b110);
    sb_in   = io.in_b[XLEN-1] & (io.in_funct3 == 3'b001 || io.in_funct3 == 3'b100 ||
                                 io.in_funct3 == 3'b110);
    amag_in = sa_in ? -io.in_a : io.in_a;
    bmag_in = sb_in ? -io.in_b : io.in_b;
    ovf_in  = io.in_funct3[2] & ~io.in_funct3[0] & (io.in_a == MIN) & (io.in_b == '1);
  end

  // one multiply step, plus the corrected result if this is the last step
  logic [XLEN:0]     msum;
  logic [2*XLEN-1:0] mul_next, mul_fin;
  logic [XLEN-1:0]   mul_res;

  always_comb begin
    msum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next = {msum, acc_q[XLEN-1:1]};
    mul_fin  = (sa_q ^ sb_q) ? -mul_next : mul_next;
    mul_res  = (f3_q == 2'b00) ? mul_fin[XLEN-1:0] : mul_fin[2*XLEN-1:XLEN];
  end

  // one restoring-division step
  logic [XLEN:0]   shifted, rem_next;
  logic [XLEN+1:0] dif;
  logic            ge;
  logic [XLEN-1:0] quo_next, quo_fin, rem_fin, div_res;

  always_comb begin
    shifted  = {rem_q[XLEN-1:0], acc_q[XLEN-1]};
    dif      = {1'b0, shifted} - {2'b00, opb_q};
    ge       = ~dif[XLEN+1];
    rem_next = ge ? dif[XLEN:0] : shifted;
    quo_next = {acc_q[XLEN-2:0], ge};
    quo_fin  = (sa_q ^ sb_q) ? -quo_next : quo_next;
    rem_fin  = sa_q ? -rem_next[XLEN-1:0] : rem_next[XLEN-1:0];
    div_res  = f3_q[1] ? rem_fin : quo_fin;
  end

  always_comb begin
    state_d = state_q;
    f3_d    = f3_q;
    tag_d   = tag_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (io.in_valid) begin
          f3_d  = io.in_funct3[1:0];
          tag_d = io.in_tag;
          sa_d  = sa_in;
          sb_d  = sb_in;
          opb_d = bmag_in;
          acc_d = {{XLEN{1'b0}}, amag_in};
          rem_d = '0;
          cnt_d = '0;
          if (!io.in_funct3[2]) begin
            state_d = S_MUL;
          end else if (io.in_b == '0) begin
            res_d   = io.in_funct3[1] ? io.in_a : '1;
            state_d = S_DONE;
          end else if (ovf_in) begin
            res_d   = io.in_funct3[1] ? '0 : MIN;
            state_d = S_DONE;
          end else begin
            state_d = S_DIV;
          end
        end
        S_MUL: begin
          acc_d = mul_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(XLEN-1)) begin
            res_d   = mul_res;
            state_d = S_DONE;
          end
        end
        S_DIV: begin
          acc_d[XLEN-1:0] = quo_next;
          rem_d           = rem_next;
          cnt_d           = cnt_q + 1'b1;
          if (cnt_q == CW'(XLEN-1)) begin
            res_d   = div_res;
            state_d = S_DONE;
          end
        end
        S_DONE: if (io.out_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      f3_q    <= '0;
      tag_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      opb_q   <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      f3_q    <= f3_d;
      tag_q   <= tag_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign io.in_ready   = (state_q == S_IDLE);
  assign io.out_valid  = (state_q == S_DONE);
  assign io.out_result = res_q;
  assign io.out_tag    = tag_q;
endmodule

// File: tb/tb_ysyx_25040109_iter_mdu.sv
// Random and directed ops against a plain-arithmetic RV32M model; latency,
// backpressure, flush and reset behaviour checked alongside results.
module tb_ysyx_25040109_iter_mdu;
  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;

  ysyx_25040109_iter_mdu_if #(.XLEN(XLEN), .TAG_W(TAG_W)) io();

  ysyx_25040109_iter_mdu #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .io   (io.slave)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] mdu_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] pa, pb, p;
    logic [63:0] pu;
    logic ovf;
    pa  = {{32{a[31]}}, a};
    pb  = {{32{b[31]}}, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = pa * pb; return p[31:0]; end
      3'd1: begin p = pa * pb; return p[63:32]; end
      3'd2: begin p = pa * $signed({32'b0, b}); return p[63:32]; end
      3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic do_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag, input int hold);
    logic [31:0] exp, r0;
    logic [4:0]  t0;
    bit fast, busy_bad, stab_bad;
    int lat, w;
    exp  = mdu_ref(f3, a, b);
    fast = f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    w = 0;
    while (!io.in_ready && w < 100) begin @(negedge clk); w++; end
    chk({nm, "/issue_rdy"}, io.in_ready, 1);
    io.in_valid = 1'b1; io.in_funct3 = f3; io.in_a = a; io.in_b = b; io.in_tag = tag;
    @(negedge clk);
    io.in_valid  = 1'b0;
    io.in_funct3 = 3'($urandom);
    io.in_a      = $urandom;
    io.in_b      = $urandom;
    io.in_tag    = 5'($urandom);
    lat = 1; busy_bad = 0;
    while (!io.out_valid && lat < 200) begin
      if (io.in_ready) busy_bad = 1;
      @(negedge clk);
      lat++;
    end
    if (io.in_ready) busy_bad = 1;
    chk({nm, "/latency"}, lat, fast ? 1 : 33);
    chk({nm, "/busy"}, busy_bad, 0);
    chk({nm, "/result"}, io.out_result, exp);
    chk({nm, "/tag"}, io.out_tag, tag);
    r0 = io.out_result; t0 = io.out_tag; stab_bad = 0;
    repeat (hold) begin
      @(negedge clk);
      if (!io.out_valid || io.in_ready || io.out_result !== r0 || io.out_tag !== t0) stab_bad = 1;
    end
    if (hold > 0) chk({nm, "/hold_stable"}, stab_bad, 0);
    io.out_ready = 1'b1;
    @(negedge clk);
    io.out_ready = 1'b0;
    chk({nm, "/rdy_after"}, io.in_ready, 1);
  endtask

  task automatic start_mul(input logic [31:0] a, input logic [31:0] b);
    io.in_valid = 1'b1; io.in_funct3 = 3'd0; io.in_a = a; io.in_b = b; io.in_tag = 5'd3;
    @(negedge clk);
    io.in_valid = 1'b0;
  endtask

  task automatic watch_quiet(input string nm);
    bit seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (io.out_valid) seen = 1;
    end
    chk({nm, "/no_valid"}, seen, 0);
  endtask

  logic [31:0] spec_vals [6];

  function automatic logic [31:0] pick();
    int k = $urandom_range(0, 9);
    if (k < 6) return spec_vals[k];
    return $urandom;
  endfunction

  initial begin
    spec_vals = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};
    io.in_valid = 0; io.in_funct3 = 0; io.in_a = 0; io.in_b = 0; io.in_tag = 0; io.out_ready = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset/in_ready", io.in_ready, 1);
    chk("reset/out_valid", io.out_valid, 0);
    chk("reset/out_result", io.out_result, 0);
    chk("reset/out_tag", io.out_tag, 0);

    do_op("mul_neg3", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 0);
    do_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 0);
    do_op("mulhu_ff", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0);
    do_op("mulhsu_ff", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 0);
    do_op("mul_min", 3'd0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 0);
    do_op("div_m7", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd6, 0);
    do_op("rem_m7", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd7, 0);
    do_op("divu_100", 3'd5, 32'd100, 32'd7, 5'd8, 0);
    do_op("remu_100", 3'd7, 32'd100, 32'd7, 5'd9, 0);
    do_op("rem_7m2", 3'd6, 32'd7, 32'hFFFF_FFFE, 5'd10, 0);
    do_op("div_by0", 3'd4, 32'd5, 32'd0, 5'd11, 0);
    do_op("remu_by0", 3'd7, 32'd5, 32'd0, 5'd12, 0);
    do_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 0);
    do_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 0);

    do_op("backpressure", 3'd0, 32'h1234_5678, 32'h9ABC_DEF1, 5'd21, 10);
    do_op("b2b_divu", 3'd5, 32'd9, 32'd3, 5'd22, 0);

    // flush at iteration 10 of a multiply
    start_mul(32'd1000, 32'd1000);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush/in_ready", io.in_ready, 1);
    chk("flush/out_valid", io.out_valid, 0);
    watch_quiet("flush");
    do_op("after_flush", 3'd0, 32'd3, 32'd4, 5'd9, 0);

    // same abort with reset; previous result 12/tag 9 must be wiped
    start_mul(32'd77, 32'd55);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid/in_ready", io.in_ready, 1);
    chk("rst_mid/out_valid", io.out_valid, 0);
    chk("rst_mid/out_result", io.out_result, 0);
    chk("rst_mid/out_tag", io.out_tag, 0);
    watch_quiet("rst_mid");

    // request alongside flush must be dropped
    io.in_valid = 1'b1; io.in_funct3 = 3'd4; io.in_a = 32'd5; io.in_b = 32'd0; io.in_tag = 5'd17;
    flush = 1'b1;
    @(negedge clk);
    io.in_valid = 1'b0;
    flush = 1'b0;
    chk("flush_req/in_ready", io.in_ready, 1);
    chk("flush_req/out_valid", io.out_valid, 0);
    watch_quiet("flush_req");

    for (int i = 0; i < 60; i++) begin
      do_op($sformatf("rand%0d_f%0d", i, i % 8), 3'(i % 8), pick(), pick(), 5'($urandom),
            $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ysyx_25040109_iter_mdu.md
# ysyx_25040109_iter_mdu

Multi-cycle RV32M multiply/divide unit that replaces the single-cycle combinational `*`, `/` and `%` paths in the execute stage. It is parametrised in datapath width, uses a radix-2 shift-add multiplier and a restoring divider, and runs behind a valid/ready handshake. The execute stage issues an M-extension op with its destination tag and stalls until the result handshake completes. The unit carries no architectural state beyond the op in flight.

## Interface
Parameters:
- `XLEN`, default 32: operand and result width; must be ≥ 4.
- `TAG_W`, default 5: width of the destination-register tag that passes through with the op.

Ports:
- `clk`  in  1  the only clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `flush`  in  1  synchronous abort of the op in flight.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  unit can accept a request this cycle.
- `in_funct3`  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `in_a`  in  XLEN  rs1 operand.
- `in_b`  in  XLEN  rs2 operand.
- `in_tag`  in  TAG_W  destination rd address.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `out_result`  out  XLEN  result.
- `out_tag`  out  TAG_W  tag captured at accept.

## Operation
- States: IDLE, MUL, DIV, DONE. `in_ready` = (state == IDLE).
- Accept happens when `in_valid && in_ready && !flush`. On accept the unit latches funct3, tag, operand signs and operand magnitudes, and clears the iteration counter.
  - funct3[2] = 0 goes to MUL.
  - funct3[2] = 1 goes to DIV, or straight to DONE on a fast path.
- Sign rules:
  - `a` is signed for MULH, MULHSU, DIV and REM.
  - `b` is signed for MULH, DIV and REM.
  - Magnitudes are XLEN-bit unsigned; |−2^(XLEN−1)| = 2^(XLEN−1) fits.
- MUL state:
  - One multiplier bit per cycle, LSB first, into a 2·XLEN accumulator; XLEN iterations.
  - Final product = negated accumulator if sign_a XOR sign_b, otherwise the accumulator.
  - MUL returns product[XLEN−1:0]. MULH, MULHSU and MULHU return product[2·XLEN−1:XLEN].
- DIV state:
  - Restoring division, one quotient bit per cycle, MSB first; XLEN iterations on an XLEN+1-bit partial remainder.
  - Quotient is negated if sign_a XOR sign_b (DIV only).
  - Remainder takes the sign of the dividend (REM only).
- Fast paths go directly to DONE with no iteration:
  - Divisor 0: DIV/DIVU return all-ones; REM/REMU return `in_a`.
  - Signed overflow, `a` = 2^(XLEN−1) and `b` = all-ones: DIV returns 2^(XLEN−1); REM returns 0.
- Result sign correction is applied when entering DONE. `out_result` is a register.
- DONE:
  - `out_valid` = 1; `out_result` and `out_tag` stay stable until `out_ready`.
  - When `out_ready` is high, the next state is IDLE.
- `flush` has priority over everything except `rst`:
  - From any state it returns the unit to IDLE next cycle and drops `out_valid`.
  - A request presented in the same cycle as `flush` is not accepted.
- X on `in_a`/`in_b` while no accept is happening must not propagate into state.

## Timing
- Reset values: state IDLE, `in_ready` 1, `out_valid` 0, `out_result` 0, `out_tag` 0, counter 0.
- Let E0 be the accept edge.
  - Iterating op: iterations run on edges E1..E_XLEN; `out_valid` is high from edge E_(XLEN+1). Latency is XLEN+1 cycles, i.e. 33 for XLEN = 32.
  - Fast-path op: `out_valid` is high from edge E1.
- The output handshake completes on the edge where `out_valid && out_ready`. `in_ready` is high in the following cycle. The minimum issue interval is therefore XLEN+2 cycles for iterating ops.
- `rst` mid-operation: the unit is in reset state after the edge and the op is discarded; no result is ever presented.
- `in_*` is sampled only on the accept edge; later changes to it have no effect.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3) → 0xFFFFFFEB and tag 5 returned. `out_valid` rises exactly 33 cycles after accept. `in_ready` is 0 throughout.
- High-half products:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
  - MUL 0x80000000 × 0xFFFFFFFF → 0x80000000.
- Division:
  - DIV −7 / 2 → 0xFFFFFFFD; REM −7 % 2 → 0xFFFFFFFF.
  - DIVU 100 / 7 → 14; REMU 100 % 7 → 2.
  - REM 7 % −2 → 1.
- Fast paths, each with `out_valid` one cycle after accept:
  - DIV 5 / 0 → 0xFFFFFFFF; REMU 5 % 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
- Backpressure: hold `out_ready` = 0 for 10 cycles after `out_valid`. `out_result` and `out_tag` stay stable and `in_ready` stays 0. Raise `out_ready`; `in_ready` = 1 on the next cycle, and a back-to-back DIVU 9/3 returns 3.
- Abort:
  - Assert `flush` at iteration 10 of a MUL: IDLE next cycle, no `out_valid` ever for that op, and the next MUL 3 × 4 returns 12.
  - Repeat with `rst` instead of `flush`: all outputs return to reset values one edge later.
  - `flush` together with `in_valid` in IDLE: the request is not accepted.
